// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared 7-segment definitions used by the digit driver and the segment reader.
// Keeping the segment table here means both ends of the bus decode and encode
// from the same source.
//   SEG_0..SEG_9, SEG_BLANK : active-low patterns, bit6 = a .. bit0 = g
//   state_e                 : reader FSM states
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001101;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    LOCKED = 1'b0,
    SETTLE = 1'b1
  } state_e;

endpackage

// File: rtl/seg_pattern_lookup.sv
// -----------------------------------------------------------------------------
// seg_pattern_lookup
// Combinational decode of an active-low 7-segment pattern back to a BCD digit.
// Ports:
//   seg_i     in  7  segment pattern, active-low, bit6 = a .. bit0 = g
//   digit_o   out 4  decoded digit 0..9 (0 when blank or illegal)
//   blank_o   out 1  pattern is all segments off
//   illegal_o out 1  pattern is neither a digit nor blank
// -----------------------------------------------------------------------------
module seg_pattern_lookup
  import seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       blank_o,
  output logic       illegal_o
);

  always_comb begin
    digit_o   = 4'd0;
    blank_o   = 1'b0;
    illegal_o = 1'b0;
    case (seg_i)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      SEG_BLANK: blank_o = 1'b1;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/segment_reader.sv
// -----------------------------------------------------------------------------
// segment_reader
// Receiving end of the 7-segment digit interface. Samples the active-low bus,
// waits for STABLE_CYCLES identical samples, then decodes the pattern and
// reports it once with a single-cycle valid pulse. Patterns that change before
// settling are counted in a saturating glitch counter.
// FSM states:
//   LOCKED | current sample already reported, nothing pending
//   SETTLE | a new pattern is being counted towards stability
// Ports:
//   clk          in  1         rising-edge clock
//   reset        in  1         synchronous, active-high
//   display      in  7         segment bus, active-low, bit6 = a .. bit0 = g
//   number       out 4         last decoded digit
//   flag         out 1         last committed pattern was blank
//   error        out 1         last committed pattern was illegal
//   valid        out 1         one-cycle pulse when number/flag/error update
//   glitch_count out GLITCH_W  abandoned patterns, saturating
// -----------------------------------------------------------------------------
module segment_reader
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3,
  parameter int GLITCH_W      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          display,
  output logic [3:0]          number,
  output logic                flag,
  output logic                error,
  output logic                valid,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam logic [CNT_W-1:0]    STABLE_C   = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);

  state_e              state_q, state_d;
  logic [6:0]          samp_q, samp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          number_q, number_d;
  logic                flag_q, flag_d;
  logic                error_q, error_d;
  logic                valid_q, valid_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  logic                match;
  logic                commit;
  logic [CNT_W-1:0]    cnt_sat;
  logic [3:0]          lk_digit;
  logic                lk_blank;
  logic                lk_illegal;

  // Decode the live bus: on every commit it either equals samp_q (stable
  // path) or is the freshly changed pattern (single-sample configuration).
  seg_pattern_lookup u_lookup (
    .seg_i     (display),
    .digit_o   (lk_digit),
    .blank_o   (lk_blank),
    .illegal_o (lk_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOCKED;
      samp_q   <= SEG_BLANK;
      cnt_q    <= '0;
      number_q <= 4'd0;
      flag_q   <= 1'b1;
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      number_q <= number_d;
      flag_q   <= flag_d;
      error_q  <= error_d;
      valid_q  <= valid_d;
      glitch_q <= glitch_d;
    end
  end

  always_comb begin
    match    = (display == samp_q);
    // Counter saturates at STABLE_CYCLES so a held pattern never wraps.
    cnt_sat  = (cnt_q >= STABLE_C) ? STABLE_C : (cnt_q + CNT_ONE);
    cnt_d    = match ? cnt_sat : CNT_ONE;
    samp_d   = display;
    state_d  = state_q;
    glitch_d = glitch_q;
    commit   = 1'b0;

    case (state_q)
      LOCKED: begin
        if (!match) begin
          if (STABLE_CYCLES == 1) commit  = 1'b1;
          else                    state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (match) begin
          if (cnt_d == STABLE_C) begin
            commit  = 1'b1;
            state_d = LOCKED;
          end
        end else begin
          if (glitch_q != '1) glitch_d = glitch_q + GLITCH_ONE;
          if (STABLE_CYCLES == 1) begin
            commit  = 1'b1;
            state_d = LOCKED;
          end
        end
      end
      default: state_d = LOCKED;
    endcase

    number_d = number_q;
    flag_d   = flag_q;
    error_d  = error_q;
    valid_d  = commit;
    if (commit) begin
      if (lk_illegal) begin
        error_d = 1'b1;
        flag_d  = 1'b0;
      end else if (lk_blank) begin
        flag_d  = 1'b1;
        error_d = 1'b0;
      end else begin
        number_d = lk_digit;
        flag_d   = 1'b0;
        error_d  = 1'b0;
      end
    end
  end

  assign number       = number_q;
  assign flag         = flag_q;
  assign error        = error_q;
  assign valid        = valid_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_segment_reader.sv
module tb_segment_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] display;
  logic [6:0] display2;

  logic [3:0] number,  number2;
  logic       flag,    flag2;
  logic       error,   error2;
  logic       valid,   valid2;
  logic [3:0] glitch,  glitch2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tbl [10];

  always #5 clk = ~clk;

  segment_reader #(.STABLE_CYCLES(4), .CNT_W(3), .GLITCH_W(4)) dut (
    .clk(clk), .reset(reset), .display(display),
    .number(number), .flag(flag), .error(error), .valid(valid),
    .glitch_count(glitch)
  );

  segment_reader #(.STABLE_CYCLES(1), .CNT_W(1), .GLITCH_W(4)) dut1 (
    .clk(clk), .reset(reset), .display(display2),
    .number(number2), .flag(flag2), .error(error2), .valid(valid2),
    .glitch_count(glitch2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int vc;
    reset = 1'b1; display = 7'b1111111; display2 = 7'b1111111;
    tick(); tick();
    n_checks++; if (number !== 4'd0) begin n_fail++; $display("FAIL reset_number got %0d exp 0", number); end
    n_checks++; if (flag !== 1'b1) begin n_fail++; $display("FAIL reset_flag got %0b exp 1", flag); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %0b exp 0", error); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", valid); end
    n_checks++; if (glitch !== 4'd0) begin n_fail++; $display("FAIL reset_glitch got %0d exp 0", glitch); end
    reset = 1'b0;
    vc = 0;
    repeat (20) begin tick(); if (valid === 1'b1) vc++; end
    n_checks++; if (vc !== 0) begin n_fail++; $display("FAIL blank_hold_valids got %0d exp 0", vc); end
    n_checks++; if (flag !== 1'b1) begin n_fail++; $display("FAIL blank_hold_flag got %0b exp 1", flag); end
    n_checks++; if (number !== 4'd0) begin n_fail++; $display("FAIL blank_hold_number got %0d exp 0", number); end
  endtask

  task automatic test_digit_latency();
    display = 7'b0010010;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_checks++;
      if (valid !== (i == 4)) begin
        n_fail++; $display("FAIL latency_valid edge %0d got %0b exp %0b", i, valid, (i == 4));
      end
    end
    n_checks++; if (number !== 4'd2) begin n_fail++; $display("FAIL digit2_number got %0d exp 2", number); end
    n_checks++; if (flag !== 1'b0) begin n_fail++; $display("FAIL digit2_flag got %0b exp 0", flag); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL digit2_error got %0b exp 0", error); end
  endtask

  task automatic test_glitch();
    int vc;
    vc = 0;
    display = 7'b0000110;
    tick(); if (valid === 1'b1) vc++;
    tick(); if (valid === 1'b1) vc++;
    display = 7'b0100100;
    repeat (8) begin tick(); if (valid === 1'b1) vc++; end
    n_checks++; if (glitch !== 4'd1) begin n_fail++; $display("FAIL glitch_count got %0d exp 1", glitch); end
    n_checks++; if (vc !== 1) begin n_fail++; $display("FAIL glitch_valids got %0d exp 1", vc); end
    n_checks++; if (number !== 4'd5) begin n_fail++; $display("FAIL glitch_number got %0d exp 5", number); end
    n_checks++; if (flag !== 1'b0) begin n_fail++; $display("FAIL glitch_flag got %0b exp 0", flag); end
  endtask

  task automatic test_illegal_blank();
    int vc;
    vc = 0;
    display = 7'b1111110;
    repeat (8) begin tick(); if (valid === 1'b1) vc++; end
    n_checks++; if (vc !== 1) begin n_fail++; $display("FAIL illegal_valids got %0d exp 1", vc); end
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL illegal_error got %0b exp 1", error); end
    n_checks++; if (flag !== 1'b0) begin n_fail++; $display("FAIL illegal_flag got %0b exp 0", flag); end
    n_checks++; if (number !== 4'd5) begin n_fail++; $display("FAIL illegal_number got %0d exp 5", number); end
    vc = 0;
    display = 7'b1111111;
    repeat (8) begin tick(); if (valid === 1'b1) vc++; end
    n_checks++; if (vc !== 1) begin n_fail++; $display("FAIL blank_valids got %0d exp 1", vc); end
    n_checks++; if (flag !== 1'b1) begin n_fail++; $display("FAIL blank_flag got %0b exp 1", flag); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL blank_error got %0b exp 0", error); end
    n_checks++; if (number !== 4'd5) begin n_fail++; $display("FAIL blank_number got %0d exp 5", number); end
  endtask

  task automatic test_reset_mid_settle();
    display = 7'b0001101;
    tick(); tick();
    reset = 1'b1;
    tick();
    n_checks++; if (number !== 4'd0) begin n_fail++; $display("FAIL midrst_number got %0d exp 0", number); end
    n_checks++; if (flag !== 1'b1) begin n_fail++; $display("FAIL midrst_flag got %0b exp 1", flag); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL midrst_error got %0b exp 0", error); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %0b exp 0", valid); end
    n_checks++; if (glitch !== 4'd0) begin n_fail++; $display("FAIL midrst_glitch got %0d exp 0", glitch); end
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_checks++;
      if (valid !== (i == 4)) begin
        n_fail++; $display("FAIL midrst_valid edge %0d got %0b exp %0b", i, valid, (i == 4));
      end
    end
    n_checks++; if (number !== 4'd7) begin n_fail++; $display("FAIL midrst_number7 got %0d exp 7", number); end
  endtask

  task automatic test_glitch_saturate();
    int vc;
    vc = 0;
    for (int i = 0; i < 20; i++) begin
      display = (i % 2 == 1) ? 7'b1001100 : 7'b1001111;
      tick(); if (valid === 1'b1) vc++;
      if (i == 9) begin
        n_checks++; if (glitch !== 4'd9) begin n_fail++; $display("FAIL glitch_mid got %0d exp 9", glitch); end
      end
    end
    n_checks++; if (glitch !== 4'd15) begin n_fail++; $display("FAIL glitch_sat got %0d exp 15", glitch); end
    n_checks++; if (vc !== 0) begin n_fail++; $display("FAIL toggle_valids got %0d exp 0", vc); end
    display = 7'b1001100;
    repeat (6) begin tick(); if (valid === 1'b1) vc++; end
    n_checks++; if (vc !== 1) begin n_fail++; $display("FAIL settle4_valids got %0d exp 1", vc); end
    n_checks++; if (number !== 4'd4) begin n_fail++; $display("FAIL settle4_number got %0d exp 4", number); end
    n_checks++; if (glitch !== 4'd15) begin n_fail++; $display("FAIL glitch_hold got %0d exp 15", glitch); end
  endtask

  task automatic test_single_cycle();
    for (int d = 0; d < 10; d++) begin
      display2 = seg_tbl[d];
      tick();
      n_checks++; if (valid2 !== 1'b1) begin n_fail++; $display("FAIL s1_valid digit %0d got %0b exp 1", d, valid2); end
      n_checks++; if (number2 !== 4'(d)) begin n_fail++; $display("FAIL s1_number got %0d exp %0d", number2, d); end
      n_checks++; if (flag2 !== 1'b0) begin n_fail++; $display("FAIL s1_flag digit %0d got %0b exp 0", d, flag2); end
      n_checks++; if (glitch2 !== 4'd0) begin n_fail++; $display("FAIL s1_glitch got %0d exp 0", glitch2); end
    end
    tick();
    n_checks++; if (valid2 !== 1'b0) begin n_fail++; $display("FAIL s1_hold_valid got %0b exp 0", valid2); end
    display2 = 7'b1111111;
    tick();
    n_checks++; if (valid2 !== 1'b1) begin n_fail++; $display("FAIL s1_blank_valid got %0b exp 1", valid2); end
    n_checks++; if (flag2 !== 1'b1) begin n_fail++; $display("FAIL s1_blank_flag got %0b exp 1", flag2); end
    n_checks++; if (number2 !== 4'd9) begin n_fail++; $display("FAIL s1_blank_number got %0d exp 9", number2); end
  endtask

  initial begin
    seg_tbl[0] = 7'b0000001; seg_tbl[1] = 7'b1001111;
    seg_tbl[2] = 7'b0010010; seg_tbl[3] = 7'b0000110;
    seg_tbl[4] = 7'b1001100; seg_tbl[5] = 7'b0100100;
    seg_tbl[6] = 7'b0100000; seg_tbl[7] = 7'b0001101;
    seg_tbl[8] = 7'b0000000; seg_tbl[9] = 7'b0000100;
    reset = 1'b1; display = 7'b1111111; display2 = 7'b1111111;
    test_reset();
    test_digit_latency();
    test_glitch();
    test_illegal_blank();
    test_reset_mid_settle();
    test_glitch_saturate();
    test_single_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
